mips_controller: RTL and testbench
==================================

// Module: mips_controller
// PURPOSE
//  Multicycle control FSM for the MIPS datapath. Decodes op/funct from the instruction
//  register and sequences fetch/decode/execute/memory/writeback one state per clk.
//  Drives every datapath mux select and write enable, plus memory read/write strobes.
//  Stalls on a memory-ready handshake. Sits beside mips_datapath inside the processor top.
// PARAMETERS
//  MEM_WAIT_EN  1  1: memory states hold until mem_ready=1; 0: mem_ready is ignored (treated as 1)
// PORTS
//  clk         in   1  clock; all state changes occur on its rising edge
//  reset       in   1  synchronous, active-high reset
//  op          in   6  instruction[31:26]
//  funct       in   6  instruction[5:0]
//  zero        in   1  ALU zero flag (combinational, valid in the same cycle)
//  mem_ready   in   1  memory completed the current read/write this cycle
//  alusrca     out  1  0=PC, 1=A register
//  alusrcb     out  2  00=B, 01=const 1, 10=imm, 11=imm (branch offset)
//  pcsource    out  2  00=ALU result, 01=ALUOut register, 10=jump target
//  pcen        out  1  PC write enable = pcwrite | (pcwritecond & zero)
//  iord        out  1  1=address from PC, 0=address from ALUOut
//  irwrite     out  1  instruction register load
//  regdst      out  1  0=rt, 1=rd
//  memtoreg    out  1  0=ALUOut, 1=MDR
//  regwrite    out  1  register file write
//  memread     out  1  memory read strobe
//  memwrite    out  1  memory write strobe
//  alucontrol  out  3  ALU operation code
//  illegal     out  1  one-cycle pulse on an undecodable op or funct
//  state       out  4  current FSM state, for probing
// BEHAVIOUR
//  - Outputs are Moore (decoded from state). Exceptions: irwrite, pcen, alucontrol in RTYPEEX.
//  - Outputs not listed for a state are 0. alucontrol defaults to ADD.
//  - Reset (sampled at the edge): state<=FETCH. While reset=1, all enables/strobes are forced 0.
//    Those are pcen, irwrite, regwrite, memread, memwrite, illegal.
//    A reset in any state abandons the instruction; no write is issued in that cycle.
//  - Opcodes: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010.
//  - FETCH   : iord=1, memread=1, alusrcb=01, pcsource=00.
//              irwrite=pcen=mem_ready. Go to DECODE on mem_ready, else hold.
//  - DECODE  : alusrcb=11 (precompute branch target). Next state by op:
//              LW/SW->MEMADR, RTYPE->RTYPEEX, BEQ->BEQEX, ADDI->ADDIEX, J->JEX.
//              Any other op: illegal=1, go to FETCH.
//  - MEMADR  : alusrca=1, alusrcb=10. LW->MEMRD, SW->MEMWR.
//  - MEMRD   : iord=0, memread=1. Go to MEMWB on mem_ready, else hold.
//  - MEMWB   : regdst=0, memtoreg=1, regwrite=1. Go to FETCH.
//  - MEMWR   : iord=0, memwrite=1. Go to FETCH on mem_ready, else hold.
//              memwrite stays high for every stall cycle.
//  - RTYPEEX : alusrca=1, alusrcb=00, alucontrol=aludec(funct). Go to RTYPEWB.
//  - RTYPEWB : regdst=1, memtoreg=0, regwrite=1. Go to FETCH.
//  - BEQEX   : alusrca=1, alusrcb=00, alucontrol=SUB, pcsource=01, pcwritecond=1.
//              Go to FETCH (PC loads only if zero=1).
//  - ADDIEX  : alusrca=1, alusrcb=10. Go to ADDIWB.
//  - ADDIWB  : regdst=0, memtoreg=0, regwrite=1. Go to FETCH.
//  - JEX     : pcsource=10, pcwrite=1. Go to FETCH.
//  - Funct decode: 100000 ADD=010, 100010 SUB=110, 100100 AND=000, 100101 OR=001,
//    101010 SLT=111, 000000 SLL=011, 000010 SRL=100.
//    Other funct: ADD, with illegal=1 in RTYPEEX; the writeback still occurs.
//  - Latency (MEM_WAIT_EN=0 or mem_ready=1): LW 5 cycles, SW/RTYPE/ADDI 4, BEQ/J 3.
// STRUCTURE
//  - Package mips_ctrl_pkg: state_t enum (FETCH=0, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
//    RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX), plus opcode, funct and ALU-op
//    localparams shared with the ALU.
//  - Sub-module mips_alu_decoder (combinational funct->alucontrol, plus illegal_funct).
//  - Top holds the state register, next-state logic and the output decode.
// TESTING
//  - Reset held 3 cycles mid-MEMWR -> memwrite=0 during reset; state=FETCH, pcen=0 on release.
//  - ADD (op=0, funct=100000), mem_ready=1 -> states 0,1,6,7,0;
//    regwrite=1, regdst=1 only in cycle 4; alucontrol=010 in RTYPEEX.
//  - LW with mem_ready low 2 cycles in MEMRD -> MEMRD held 3 cycles, memread=1 and iord=0 throughout;
//    MEMWB asserts memtoreg=1, regwrite=1.
//  - BEQ: zero=1 -> pcen=1, pcsource=01 in BEQEX; repeat with zero=0 -> pcen=0 in BEQEX.
//  - J (op=000010) -> JEX: pcen=1, pcsource=10. SW: memwrite=1 exactly 1 cycle with mem_ready=1.
//  - op=111111 -> illegal pulses 1 cycle in DECODE, no regwrite/memwrite; FETCH follows.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcodes, functs, ALU ops.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_ctrl_pkg;

    // One state per clock of the multicycle instruction sequence.
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    // Primary opcodes (instruction[31:26]).
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type function codes (instruction[5:0]).
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;

    // ALU operation codes, shared with the ALU.
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SLL = 3'b011;
    localparam logic [2:0] ALU_SRL = 3'b100;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mips_alu_decoder.sv
// R-type funct decode: selects the ALU operation code and flags unimplemented functs.
// Latency: purely combinational.
// Backpressure: none.
module mips_alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alucontrol,
    output logic       illegal_funct
);

    // Unknown functs fall back to ADD so the writeback still produces a defined value.
    always_comb begin
        alucontrol    = ALU_ADD;
        illegal_funct = 1'b0;
        case (funct)
            FN_ADD:  alucontrol = ALU_ADD;
            FN_SUB:  alucontrol = ALU_SUB;
            FN_AND:  alucontrol = ALU_AND;
            FN_OR:   alucontrol = ALU_OR;
            FN_SLT:  alucontrol = ALU_SLT;
            FN_SLL:  alucontrol = ALU_SLL;
            FN_SRL:  alucontrol = ALU_SRL;
            default: illegal_funct = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback, drives datapath selects.
// Latency: LW 5 cycles, SW/R-type/ADDI 4, BEQ/J 3, plus one per memory stall cycle.
// Backpressure: FETCH, MEMRD and MEMWR hold until mem_ready (when MEM_WAIT_EN=1), strobes stay asserted.
module mips_controller
    import mips_ctrl_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsource,
    output logic       pcen,
    output logic       iord,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       memread,
    output logic       memwrite,
    output logic [2:0] alucontrol,
    output logic       illegal,
    output logic [3:0] state
);

    state_t     state_q;
    state_t     state_d;
    logic       mem_rdy;
    logic       pcwrite;
    logic       pcwritecond;
    logic [2:0] dec_alucontrol;
    logic       dec_illegal;

    assign mem_rdy = MEM_WAIT_EN ? mem_ready : 1'b1;
    assign state   = state_q;

    mips_alu_decoder u_alu_decoder (
        .funct         (funct),
        .alucontrol    (dec_alucontrol),
        .illegal_funct (dec_illegal)
    );

    // State register; reset abandons whatever instruction is in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode. Outputs are Moore except irwrite/pcen (mem_ready, zero)
    // and the R-type ALU op/illegal flag (funct).
    always_comb begin
        state_d     = state_q;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        pcsource    = 2'b00;
        iord        = 1'b0;
        irwrite     = 1'b0;
        regdst      = 1'b0;
        memtoreg    = 1'b0;
        regwrite    = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        alucontrol  = ALU_ADD;
        illegal     = 1'b0;
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        pcen        = 1'b0;

        case (state_q)
            FETCH: begin
                iord    = 1'b1;
                memread = 1'b1;
                alusrcb = 2'b01;
                irwrite = mem_rdy;
                pcwrite = mem_rdy;
                if (mem_rdy) state_d = DECODE;
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JEX;
                    default: begin
                        illegal = 1'b1;
                        state_d = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (op == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                memread = 1'b1;
                if (mem_rdy) state_d = MEMWB;
            end
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
                state_d  = FETCH;
            end
            MEMWR: begin
                memwrite = 1'b1;
                if (mem_rdy) state_d = FETCH;
            end
            RTYPEEX: begin
                alusrca    = 1'b1;
                alucontrol = dec_alucontrol;
                illegal    = dec_illegal;
                state_d    = RTYPEWB;
            end
            RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
                state_d  = FETCH;
            end
            BEQEX: begin
                alusrca     = 1'b1;
                alucontrol  = ALU_SUB;
                pcsource    = 2'b01;
                pcwritecond = 1'b1;
                state_d     = FETCH;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = ADDIWB;
            end
            ADDIWB: begin
                regwrite = 1'b1;
                state_d  = FETCH;
            end
            JEX: begin
                pcsource = 2'b10;
                pcwrite  = 1'b1;
                state_d  = FETCH;
            end
            default: state_d = FETCH;
        endcase

        pcen = pcwrite | (pcwritecond & zero);

        // No write or strobe may escape while reset is held.
        if (reset) begin
            pcen     = 1'b0;
            irwrite  = 1'b0;
            regwrite = 1'b0;
            memread  = 1'b0;
            memwrite = 1'b0;
            illegal  = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_controller.sv
// Directed bench for mips_controller: per-cycle vector table plus a stalled-store sequence.
// Latency: n/a.
// Backpressure: mem_ready driven low in FETCH, MEMRD and MEMWR stall cases.
module tb_mips_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsource;
    logic       pcen;
    logic       iord;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic [2:0] alucontrol;
    logic       illegal;
    logic [3:0] state;

    mips_controller #(.MEM_WAIT_EN(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsource   (pcsource),
        .pcen       (pcen),
        .iord       (iord),
        .irwrite    (irwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .memread    (memread),
        .memwrite   (memwrite),
        .alucontrol (alucontrol),
        .illegal    (illegal),
        .state      (state)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] BAD  = 6'b111111;
    localparam logic [5:0] FADD = 6'b100000;
    localparam logic [2:0] AADD = 3'b010;
    localparam logic [2:0] ASUB = 3'b110;

    // One record per clock: inputs held for that cycle and the outputs required in it.
    // o = {alusrca, alusrcb, pcsource, pcen, iord, irwrite, regdst, memtoreg, regwrite,
    //      memread, memwrite, alucontrol, illegal}
    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        rdy;
        logic [3:0]  st;
        logic [16:0] o;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic add_vec(input logic rst, input logic [5:0] vop, input logic [5:0] vfn,
                           input logic z, input logic rdy, input logic [3:0] st,
                           input logic srca, input logic [1:0] srcb, input logic [1:0] pcs,
                           input logic e_pcen, input logic e_iord, input logic irw,
                           input logic rdst, input logic m2r, input logic rw,
                           input logic mrd, input logic mwr, input logic [2:0] aluc,
                           input logic ill);
        vec_t v;
        v.rst = rst; v.op = vop; v.fn = vfn; v.z = z; v.rdy = rdy; v.st = st;
        v.o = {srca, srcb, pcs, e_pcen, e_iord, irw, rdst, m2r, rw, mrd, mwr, aluc, ill};
        vecs.push_back(v);
    endtask

    logic [5:0] fn_tab  [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                6'b101010, 6'b000000, 6'b000010, 6'b111111};
    logic [2:0] alu_tab [8] = '{3'b010, 3'b110, 3'b000, 3'b001,
                                3'b111, 3'b011, 3'b100, 3'b010};
    logic       ill_tab [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    logic [16:0] act;

    initial begin
        //       rst op    fn    z  rdy st  sa sb     pcs    pe io iw rd mr rw rd wr alu   il
        // reset held in FETCH: strobes forced low, selects unchanged
        add_vec(1, RT,   FADD, 0, 1, 0,  0, 2'b01, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, AADD, 0);
        // ADD: 0,1,6,7
        add_vec(0, RT,   FADD, 0, 1, 0,  0, 2'b01, 2'b00, 1, 1, 1, 0, 0, 0, 1, 0, AADD, 0);
        add_vec(0, RT,   FADD, 0, 1, 1,  0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, AADD, 0);
        add_vec(0, RT,   FADD, 0, 1, 6,  1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, AADD, 0);
        add_vec(0, RT,   FADD, 0, 1, 7,  0, 2'b00, 2'b00, 0, 0, 0, 1, 0, 1, 0, 0, AADD, 0);
        // every funct, including an undecodable one (illegal but still written back)
        for (int k = 0; k < 8; k++) begin
            add_vec(0, RT, fn_tab[k], 0, 1, 0, 0, 2'b01, 2'b00, 1, 1, 1, 0, 0, 0, 1, 0, AADD, 0);
            add_vec(0, RT, fn_tab[k], 0, 1, 1, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, AADD, 0);
            add_vec(0, RT, fn_tab[k], 0, 1, 6, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, alu_tab[k], ill_tab[k]);
            add_vec(0, RT, fn_tab[k], 0, 1, 7, 0, 2'b00, 2'b00, 0, 0, 0, 1, 0, 1, 0, 0, AADD, 0);
        end
        // LW: one FETCH stall, MEMRD held 3 cycles
        add_vec(0, LW,   FADD, 0, 0, 0,  0, 2'b01, 2'b00, 0, 1, 0, 0, 0, 0, 1, 0, AADD, 0);
        add_vec(0, LW,   FADD, 0, 1, 0,  0, 2'b01, 2'b00, 1, 1, 1, 0, 0, 0, 1, 0, AADD, 0);
        add_vec(0, LW,   FADD, 0, 1, 1,  0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, AADD, 0);
        add_vec(0, LW,   FADD, 0, 1, 2,  1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, AADD, 0);
        add_vec(0, LW,   FADD, 0, 0, 3,  0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, AADD, 0);
        add_vec(0, LW,   FADD, 0, 0, 3,  0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, AADD, 0);
        add_vec(0, LW,   FADD, 0, 1, 3,  0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, AADD, 0);
        add_vec(0, LW,   FADD, 0, 1, 4,  0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0, AADD, 0);
        // SW with no stall
        add_vec(0, SW,   FADD, 0, 1, 0,  0, 2'b01, 2'b00, 1, 1, 1, 0, 0, 0, 1, 0, AADD, 0);
        add_vec(0, SW,   FADD, 0, 1, 1,  0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, AADD, 0);
        add_vec(0, SW,   FADD, 0, 1, 2,  1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, AADD, 0);
        add_vec(0, SW,   FADD, 0, 1, 5,  0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, AADD, 0);
        // BEQ taken (zero=1, including in DECODE where it must not move the PC)
        add_vec(0, BEQ,  FADD, 1, 1, 0,  0, 2'b01, 2'b00, 1, 1, 1, 0, 0, 0, 1, 0, AADD, 0);
        add_vec(0, BEQ,  FADD, 1, 1, 1,  0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, AADD, 0);
        add_vec(0, BEQ,  FADD, 1, 1, 8,  1, 2'b00, 2'b01, 1, 0, 0, 0, 0, 0, 0, 0, ASUB, 0);
        // BEQ not taken
        add_vec(0, BEQ,  FADD, 0, 1, 0,  0, 2'b01, 2'b00, 1, 1, 1, 0, 0, 0, 1, 0, AADD, 0);
        add_vec(0, BEQ,  FADD, 0, 1, 1,  0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, AADD, 0);
        add_vec(0, BEQ,  FADD, 0, 1, 8,  1, 2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, ASUB, 0);
        // ADDI
        add_vec(0, ADDI, FADD, 0, 1, 0,  0, 2'b01, 2'b00, 1, 1, 1, 0, 0, 0, 1, 0, AADD, 0);
        add_vec(0, ADDI, FADD, 0, 1, 1,  0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, AADD, 0);
        add_vec(0, ADDI, FADD, 0, 1, 9,  1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, AADD, 0);
        add_vec(0, ADDI, FADD, 0, 1, 10, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0, AADD, 0);
        // J
        add_vec(0, JMP,  FADD, 0, 1, 0,  0, 2'b01, 2'b00, 1, 1, 1, 0, 0, 0, 1, 0, AADD, 0);
        add_vec(0, JMP,  FADD, 0, 1, 1,  0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, AADD, 0);
        add_vec(0, JMP,  FADD, 0, 1, 11, 0, 2'b00, 2'b10, 1, 0, 0, 0, 0, 0, 0, 0, AADD, 0);
        // undecodable opcode: illegal in DECODE, straight back to FETCH
        add_vec(0, BAD,  FADD, 0, 1, 0,  0, 2'b01, 2'b00, 1, 1, 1, 0, 0, 0, 1, 0, AADD, 0);
        add_vec(0, BAD,  FADD, 0, 1, 1,  0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, AADD, 1);
        // SW stalled in MEMWR, then reset held 3 cycles
        add_vec(0, SW,   FADD, 0, 1, 0,  0, 2'b01, 2'b00, 1, 1, 1, 0, 0, 0, 1, 0, AADD, 0);
        add_vec(0, SW,   FADD, 0, 1, 1,  0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, AADD, 0);
        add_vec(0, SW,   FADD, 0, 1, 2,  1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, AADD, 0);
        add_vec(0, SW,   FADD, 0, 0, 5,  0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, AADD, 0);
        add_vec(1, SW,   FADD, 0, 0, 5,  0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, AADD, 0);
        add_vec(1, SW,   FADD, 0, 0, 0,  0, 2'b01, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, AADD, 0);
        add_vec(1, SW,   FADD, 0, 0, 0,  0, 2'b01, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, AADD, 0);
        add_vec(0, SW,   FADD, 0, 0, 0,  0, 2'b01, 2'b00, 0, 1, 0, 0, 0, 0, 1, 0, AADD, 0);

        // initial reset to bring the state register out of X
        reset = 1'b1; op = RT; funct = FADD; zero = 1'b0; mem_ready = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            reset = vecs[i].rst; op = vecs[i].op; funct = vecs[i].fn;
            zero = vecs[i].z; mem_ready = vecs[i].rdy;
            @(negedge clk);
            act = {alusrca, alusrcb, pcsource, pcen, iord, irwrite, regdst, memtoreg,
                   regwrite, memread, memwrite, alucontrol, illegal};
            n_vec++;
            if (state !== vecs[i].st || act !== vecs[i].o) begin
                n_miss++;
                $display("FAIL vec%0d state got %0d want %0d, outs got %b want %b",
                         i, state, vecs[i].st, act, vecs[i].o);
            end
            @(posedge clk); #1;
        end

        // SW held in MEMWR for 3 stall cycles: memwrite must stay up for all 4 MEMWR cycles
        begin
            int  mw_cycles = 0;
            int  stalls    = 3;
            int  guard     = 0;
            bit  seen_mw   = 1'b0;
            bit  done      = 1'b0;
            reset = 1'b0; op = SW; funct = FADD; zero = 1'b0;
            while (!done && guard < 30) begin
                if (state == 4'd5) begin
                    seen_mw   = 1'b1;
                    mem_ready = (stalls == 0);
                    if (stalls > 0) stalls--;
                end else begin
                    mem_ready = 1'b1;
                end
                @(negedge clk);
                if (memwrite) mw_cycles++;
                @(posedge clk); #1;
                guard++;
                if (seen_mw && state == 4'd0) done = 1'b1;
            end
            n_vec++;
            if (!done) begin
                n_miss++;
                $display("FAIL sw_stall_timeout state got %0d want 0 within 30 cycles", state);
            end
            n_vec++;
            if (mw_cycles != 4) begin
                n_miss++;
                $display("FAIL sw_stall_memwrite_cycles got %0d want 4", mw_cycles);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
